// File: rtl/apb_exe_ctrl.sv
// apb_exe_ctrl: APB3 slave front-end that owns the exe unit's inputs and captures its results.
// Optional: define APB_EXE_SLVERR_EN to report illegal accesses on o_pslverr.
//
// Ports:
//   i_clk, i_rsn            clock, synchronous active-low reset
//   i_psel .. i_pwdata      APB3 request (byte address, bits[1:0] ignored)
//   o_prdata/o_pready/o_pslverr  APB3 response
//   o_argA/o_argB/o_oper    operands and opcode driven to the exe unit
//   i_result/i_status       registered result and {ERROR,ODD,ZERO,NEG} from the exe unit
//   o_done                  level copy of STATUS.DONE
//
// Register map (word registers):
//   0x00 ARG_A RW   0x04 ARG_B RW   0x08 OPER RW
//   0x0C CTRL  WO   bit0 START, bit1 CLR_DONE
//   0x10 RESULT RO  0x14 STATUS RO  bit0 BUSY, bit1 DONE, bits[7:4] captured status
module apb_exe_ctrl #(
    parameter int MBIT = 4,
    parameter int NBIT = 2,
    parameter int AW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rsn,
    input  logic            i_psel,
    input  logic            i_penable,
    input  logic            i_pwrite,
    input  logic [AW-1:0]   i_paddr,
    input  logic [31:0]     i_pwdata,
    output logic [31:0]     o_prdata,
    output logic            o_pready,
    output logic            o_pslverr,
    output logic [MBIT-1:0] o_argA,
    output logic [MBIT-1:0] o_argB,
    output logic [NBIT-1:0] o_oper,
    input  logic [MBIT-1:0] i_result,
    input  logic [3:0]      i_status,
    output logic            o_done
);

    localparam int IW = AW - 2;

    localparam logic [IW-1:0] IDX_ARGA = IW'(0);
    localparam logic [IW-1:0] IDX_ARGB = IW'(1);
    localparam logic [IW-1:0] IDX_OPER = IW'(2);
    localparam logic [IW-1:0] IDX_CTRL = IW'(3);
    localparam logic [IW-1:0] IDX_RES  = IW'(4);
    localparam logic [IW-1:0] IDX_STAT = IW'(5);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_CAPTURE
    } state_t;

    state_t          state_q;
    logic [MBIT-1:0] arga_q;
    logic [MBIT-1:0] argb_q;
    logic [NBIT-1:0] oper_q;
    logic [MBIT-1:0] result_q;
    logic [3:0]      stat_q;
    logic            done_q;

    logic [IW-1:0]   widx;
    logic            acc;
    logic            busy;
    logic            stall;
    logic            wr_ok;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign widx  = i_paddr[AW-1:2];
    assign acc   = i_psel & i_penable;
    assign busy  = (state_q != S_IDLE);

    // A RESULT read issued while an operation is in flight is held
    // until the capture edge so it returns the fresh result.
    assign stall = acc & ~i_pwrite & (widx == IDX_RES) & busy;

    // Writes land only in IDLE; operands stay frozen while the exe unit works.
    assign wr_ok = acc & i_pwrite & ~busy;

    assign unused_bits = ^{i_paddr[1:0], i_pwdata};

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            state_q  <= S_IDLE;
            arga_q   <= '0;
            argb_q   <= '0;
            oper_q   <= '0;
            result_q <= '0;
            stat_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (wr_ok) begin
                        case (widx)
                            IDX_ARGA: arga_q <= i_pwdata[MBIT-1:0];
                            IDX_ARGB: argb_q <= i_pwdata[MBIT-1:0];
                            IDX_OPER: oper_q <= i_pwdata[NBIT-1:0];
                            IDX_CTRL: begin
                                // START takes priority; it clears DONE as well.
                                if (i_pwdata[0]) begin
                                    state_q <= S_LAUNCH;
                                    done_q  <= 1'b0;
                                end else if (i_pwdata[1]) begin
                                    done_q  <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_LAUNCH: begin
                    // exe unit registers its output on this edge
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    result_q <= i_result;
                    stat_q   <= i_status;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (i_rsn && acc && !i_pwrite && !stall) begin
            case (widx)
                IDX_ARGA: rdata[MBIT-1:0] = arga_q;
                IDX_ARGB: rdata[MBIT-1:0] = argb_q;
                IDX_OPER: rdata[NBIT-1:0] = oper_q;
                IDX_RES:  rdata[MBIT-1:0] = result_q;
                IDX_STAT: begin
                    rdata[7:4] = stat_q;
                    rdata[1]   = done_q;
                    rdata[0]   = busy;
                end
                default:  rdata = '0;
            endcase
        end
    end

    assign o_prdata = rdata;
    assign o_pready = ~i_rsn | ~stall;

`ifdef APB_EXE_SLVERR_EN
    logic unmapped;
    logic ro_wr;
    logic wo_rd;
    logic busy_wr;

    assign unmapped = (widx > IDX_STAT);
    assign ro_wr    = i_pwrite & ((widx == IDX_RES) | (widx == IDX_STAT));
    assign wo_rd    = ~i_pwrite & (widx == IDX_CTRL);
    assign busy_wr  = i_pwrite & busy & (widx <= IDX_CTRL);

    assign o_pslverr = i_rsn & acc & o_pready &
                       (unmapped | ro_wr | wo_rd | busy_wr);
`else
    assign o_pslverr = 1'b0;
`endif

    assign o_argA = arga_q;
    assign o_argB = argb_q;
    assign o_oper = oper_q;
    assign o_done = done_q;

endmodule
